mmio_interconnect: RTL

Parametrised, registered successor to the combinational memory-mapped I/O decoder: it sits between the CPU data port and up to N_SLAVES peripherals (RAM, counter, pitch generator, graphic processor, PS/2, GPIO, switches). It decodes each CPU access by the top address nibble and runs a request/ready handshake with the selected slave, so slow slaves can insert wait states. Unmapped addresses and slaves that do not answer within a bounded time complete with an error flag instead of hanging the bus.

---
 rtl/mmio_interconnect.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/mmio_interconnect.sv
// Registered MMIO interconnect: decodes CPU accesses by addr[31:28] and runs a
// request/ready handshake with the selected slave, with timeout and unmapped-address errors.
module mmio_interconnect #(
  parameter int                      N_SLAVES   = 7,
  parameter logic [4*N_SLAVES-1:0]   SLAVE_BASE = {4'hf, 4'he, 4'hd, 4'hc, 4'h2, 4'h1, 4'h0},
  parameter int                      TIMEOUT    = 16,
  parameter logic [31:0]             ERR_DATA   = 32'h0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cpu_req,
  input  logic                     cpu_we,
  input  logic [31:0]              cpu_addr,
  input  logic [31:0]              cpu_wdata,
  output logic [31:0]              cpu_rdata,
  output logic                     cpu_ready,
  output logic                     cpu_err,
  output logic [N_SLAVES-1:0]      s_sel,
  output logic                     s_we,
  output logic [31:0]              s_addr,
  output logic [31:0]              s_wdata,
  input  logic [32*N_SLAVES-1:0]   s_rdata,
  input  logic [N_SLAVES-1:0]      s_ready
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX   = '1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  logic [1:0]          state_q,     state_d;
  logic                cpu_ready_q, cpu_ready_d;
  logic                cpu_err_q,   cpu_err_d;
  logic [31:0]         cpu_rdata_q, cpu_rdata_d;
  logic [N_SLAVES-1:0] s_sel_q,     s_sel_d;
  logic                s_we_q,      s_we_d;
  logic [31:0]         s_addr_q,    s_addr_d;
  logic [31:0]         s_wdata_q,   s_wdata_d;
  logic [CW-1:0]       cnt_q,       cnt_d;

  logic [N_SLAVES-1:0] hit_vec;
  logic [31:0]         sel_rdata;
  logic                sel_ready;

  // Descending scan so that the lowest matching index is written last and wins.
  always_comb begin
    hit_vec = '0;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if (cpu_addr[31:28] == SLAVE_BASE[4*i +: 4]) begin
        hit_vec    = '0;
        hit_vec[i] = 1'b1;
      end
    end
  end

  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (s_sel_q[i]) begin
        sel_rdata = sel_rdata | s_rdata[32*i +: 32];
      end
    end
  end

  assign sel_ready = |(s_ready & s_sel_q);

  always_comb begin
    state_d     = state_q;
    cpu_ready_d = 1'b0;
    cpu_err_d   = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    s_sel_d     = s_sel_q;
    s_we_d      = s_we_q;
    s_addr_d    = s_addr_q;
    s_wdata_d   = s_wdata_q;
    cnt_d       = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (cpu_req) begin
          s_addr_d  = cpu_addr;
          s_wdata_d = cpu_wdata;
          cnt_d     = '0;
          if (|hit_vec) begin
            state_d = ST_ACCESS;
            s_sel_d = hit_vec;
            s_we_d  = cpu_we;
          end else begin
            state_d     = ST_RESP;
            cpu_ready_d = 1'b1;
            cpu_err_d   = 1'b1;
            cpu_rdata_d = ERR_DATA;
            s_sel_d     = '0;
            s_we_d      = 1'b0;
          end
        end
      end

      ST_ACCESS: begin
        // A slave answer in the same cycle as the timeout still completes normally.
        if (sel_ready) begin
          state_d     = ST_RESP;
          cpu_ready_d = 1'b1;
          s_sel_d     = '0;
          s_we_d      = 1'b0;
          if (!s_we_q) begin
            cpu_rdata_d = sel_rdata;
          end
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_LIMIT)) begin
          state_d     = ST_RESP;
          cpu_ready_d = 1'b1;
          cpu_err_d   = 1'b1;
          cpu_rdata_d = ERR_DATA;
          s_sel_d     = '0;
          s_we_d      = 1'b0;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        s_sel_d = '0;
        s_we_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cpu_ready_q <= 1'b0;
      cpu_err_q   <= 1'b0;
      cpu_rdata_q <= '0;
      s_sel_q     <= '0;
      s_we_q      <= 1'b0;
      s_addr_q    <= '0;
      s_wdata_q   <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      cpu_ready_q <= cpu_ready_d;
      cpu_err_q   <= cpu_err_d;
      cpu_rdata_q <= cpu_rdata_d;
      s_sel_q     <= s_sel_d;
      s_we_q      <= s_we_d;
      s_addr_q    <= s_addr_d;
      s_wdata_q   <= s_wdata_d;
      cnt_q       <= cnt_d;
    end
  end

  assign cpu_ready = cpu_ready_q;
  assign cpu_err   = cpu_err_q;
  assign cpu_rdata = cpu_rdata_q;
  assign s_sel     = s_sel_q;
  assign s_we      = s_we_q;
  assign s_addr    = s_addr_q;
  assign s_wdata   = s_wdata_q;

endmodule
